// File: rtl/instruction_mem_pipe.sv
// Word-addressed instruction store with registered read pipeline,
// valid/ready fetch handshake, program-load port and fault reporting.
module instruction_mem_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000013,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_fault,
  input  logic                  flush,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_wdata
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int AW = $clog2(DEPTH);
  localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]         req_idx;
  logic [IW-1:0]         prog_idx;
  logic                  req_oor;
  logic                  req_mis;
  logic                  prog_oor;
  logic                  advance;
  logic                  accept;
  logic [1:0]            rd_fault;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_prog_lsb;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [1:0]            s1_fault;

  assign req_idx  = req_addr[ADDR_WIDTH-1:2];
  assign prog_idx = prog_addr[ADDR_WIDTH-1:2];
  assign req_oor  = req_idx >= DEPTH_IDX;
  assign prog_oor = prog_idx >= DEPTH_IDX;
  assign req_mis  = |req_addr[1:0];
  assign unused_prog_lsb = ^prog_addr[1:0];

  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = advance && !flush && !reset;
  assign accept    = req_valid && req_ready;

  assign rd_fault = {req_oor, req_mis};
  assign rd_word  = mem[req_idx[AW-1:0]];
  assign rd_data  = (|rd_fault) ? NOP_WORD : rd_word;

  // Power-up contents: zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Program-load write; the read above sees the pre-write word.
  always_ff @(posedge clk) begin
    if (!reset && prog_we && !prog_oor)
      mem[prog_idx[AW-1:0]] <= prog_wdata;
  end

  // Memory read register: first pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= NOP_WORD;
      s1_fault <= 2'b00;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_data  <= rd_data;
      s1_fault <= rd_fault;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;
      logic [1:0]            s2_fault;

      // Output stage for the two-cycle configuration.
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_valid <= 1'b0;
          s2_data  <= NOP_WORD;
          s2_fault <= 2'b00;
        end else if (flush) begin
          s2_valid <= 1'b0;
        end else if (advance) begin
          s2_valid <= s1_valid;
          s2_data  <= s1_data;
          s2_fault <= s1_fault;
        end
      end

      assign rsp_valid = s2_valid;
      assign rsp_data  = s2_data;
      assign rsp_fault = s2_fault;
    end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_data  = s1_data;
      assign rsp_fault = s1_fault;
    end
  endgenerate

endmodule

// File: tb/tb_instruction_mem_pipe.sv
// Directed bench: latency-1 instance for load/fetch/faults,
// latency-2 instance for stall, flush, collision and reset.
module tb_instruction_mem_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_req_valid, a_req_ready, a_rsp_valid;
  logic        a_rsp_ready, a_flush, a_prog_we;
  logic [31:0] a_req_addr, a_rsp_data, a_prog_addr, a_prog_wdata;
  logic [1:0]  a_rsp_fault;

  logic        b_reset, b_req_valid, b_req_ready, b_rsp_valid;
  logic        b_rsp_ready, b_flush, b_prog_we;
  logic [31:0] b_req_addr, b_rsp_data, b_prog_addr, b_prog_wdata;
  logic [1:0]  b_rsp_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] bw [5];
  logic [31:0] ba [5];

  instruction_mem_pipe #(
    .READ_LATENCY(1)
  ) u_lat1 (
    .clk(clk),
    .reset(a_reset),
    .req_valid(a_req_valid),
    .req_ready(a_req_ready),
    .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready),
    .rsp_data(a_rsp_data),
    .rsp_fault(a_rsp_fault),
    .flush(a_flush),
    .prog_we(a_prog_we),
    .prog_addr(a_prog_addr),
    .prog_wdata(a_prog_wdata)
  );

  instruction_mem_pipe #(
    .READ_LATENCY(2)
  ) u_lat2 (
    .clk(clk),
    .reset(b_reset),
    .req_valid(b_req_valid),
    .req_ready(b_req_ready),
    .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready),
    .rsp_data(b_rsp_data),
    .rsp_fault(b_rsp_fault),
    .flush(b_flush),
    .prog_we(b_prog_we),
    .prog_addr(b_prog_addr),
    .prog_wdata(b_prog_wdata)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bw[0] = 32'h00000093; ba[0] = 32'h0;
    bw[1] = 32'h00A28513; ba[1] = 32'h4;
    bw[2] = 32'h00200193; ba[2] = 32'h8;
    bw[3] = 32'h00300213; ba[3] = 32'hC;
    bw[4] = 32'h11111111; ba[4] = 32'h10;

    a_reset = 1; a_req_valid = 0; a_req_addr = 0; a_rsp_ready = 1;
    a_flush = 0; a_prog_we = 0; a_prog_addr = 0; a_prog_wdata = 0;
    b_reset = 1; b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 1;
    b_flush = 0; b_prog_we = 0; b_prog_addr = 0; b_prog_wdata = 0;

    #1;
    check("a_rdy_in_reset", a_req_ready, 0);
    check("b_rdy_in_reset", b_req_ready, 0);
    tick();
    check("a_rst_valid", a_rsp_valid, 0);
    check("a_rst_data", a_rsp_data, NOP);
    check("a_rst_fault", a_rsp_fault, 0);
    check("b_rst_valid", b_rsp_valid, 0);
    check("b_rst_data", b_rsp_data, NOP);
    a_reset = 0; b_reset = 0;
    #1;
    check("a_rdy_post_rst", a_req_ready, 1);
    check("b_rdy_post_rst", b_req_ready, 1);

    // Latency 1: program load, then fetch.
    a_prog_we = 1; a_prog_addr = 32'h4; a_prog_wdata = 32'h00A28513;
    tick();
    a_prog_we = 0;
    a_req_valid = 1; a_req_addr = 32'h4;
    tick();
    check("a_ld_valid", a_rsp_valid, 1);
    check("a_ld_data", a_rsp_data, 32'h00A28513);
    check("a_ld_fault", a_rsp_fault, 0);
    a_req_addr = 32'h8;
    tick();
    check("a_unloaded", a_rsp_data, 0);

    // Latency 1: faults back to back.
    a_req_addr = 32'h6;
    tick();
    check("a_mis_data", a_rsp_data, NOP);
    check("a_mis_fault", a_rsp_fault, 2'b01);
    a_req_addr = 32'h1000;
    tick();
    check("a_oor_data", a_rsp_data, NOP);
    check("a_oor_fault", a_rsp_fault, 2'b10);
    a_req_addr = 32'h1002;
    tick();
    check("a_both_fault", a_rsp_fault, 2'b11);
    a_req_addr = 32'h4;
    tick();
    check("a_after_data", a_rsp_data, 32'h00A28513);
    check("a_after_fault", a_rsp_fault, 0);
    a_req_valid = 0;
    tick();
    check("a_idle", a_rsp_valid, 0);

    // Latency 2: load image.
    for (int i = 0; i < 5; i++) begin
      b_prog_we = 1; b_prog_addr = ba[i]; b_prog_wdata = bw[i];
      tick();
    end
    b_prog_we = 0;

    // Backpressure.
    b_req_valid = 1; b_req_addr = 32'h0;
    tick();
    b_req_addr = 32'h4;
    tick();
    check("bp_first_valid", b_rsp_valid, 1);
    check("bp_first_data", b_rsp_data, bw[0]);
    b_req_addr = 32'h8; b_rsp_ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy_stall", b_req_ready, 0);
      tick();
      check("bp_hold_valid", b_rsp_valid, 1);
      check("bp_hold_data", b_rsp_data, bw[0]);
    end
    b_rsp_ready = 1;
    #1;
    check("bp_rdy_release", b_req_ready, 1);
    tick();
    b_req_valid = 0;
    check("bp_w1", b_rsp_data, bw[1]);
    check("bp_w1_valid", b_rsp_valid, 1);
    tick();
    check("bp_w2", b_rsp_data, bw[2]);
    check("bp_w2_valid", b_rsp_valid, 1);
    tick();
    check("bp_drained", b_rsp_valid, 0);

    // Flush with two requests in flight.
    b_req_valid = 1; b_req_addr = 32'h0;
    tick();
    b_req_addr = 32'h4;
    tick();
    b_req_valid = 0; b_rsp_ready = 0; b_flush = 1;
    #1;
    check("fl_rdy", b_req_ready, 0);
    tick();
    b_flush = 0; b_rsp_ready = 1;
    check("fl_valid", b_rsp_valid, 0);
    b_req_valid = 1; b_req_addr = 32'hC;
    #1;
    check("fl_rdy_after", b_req_ready, 1);
    tick();
    b_req_valid = 0;
    check("fl_gap", b_rsp_valid, 0);
    tick();
    check("fl_c_valid", b_rsp_valid, 1);
    check("fl_c_data", b_rsp_data, bw[3]);
    tick();
    check("fl_empty", b_rsp_valid, 0);

    // Write/read collision.
    b_prog_we = 1; b_prog_addr = 32'h10; b_prog_wdata = 32'h22222222;
    b_req_valid = 1; b_req_addr = 32'h10;
    tick();
    b_prog_we = 0;
    tick();
    b_req_valid = 0;
    check("col_old", b_rsp_data, 32'h11111111);
    tick();
    check("col_new", b_rsp_data, 32'h22222222);
    tick();

    // Reset mid-operation; write during reset is ignored.
    b_req_valid = 1; b_req_addr = 32'h8;
    tick();
    b_req_valid = 0; b_reset = 1;
    b_prog_we = 1; b_prog_addr = 32'h14; b_prog_wdata = 32'hDEADBEEF;
    #1;
    check("mr_rdy", b_req_ready, 0);
    tick();
    b_reset = 0; b_prog_we = 0;
    check("mr_valid", b_rsp_valid, 0);
    check("mr_data", b_rsp_data, NOP);
    check("mr_fault", b_rsp_fault, 0);
    tick();
    check("mr_dropped", b_rsp_valid, 0);
    b_req_valid = 1; b_req_addr = 32'h4;
    tick();
    b_req_addr = 32'h14;
    tick();
    b_req_valid = 0;
    check("mr_keep_valid", b_rsp_valid, 1);
    check("mr_keep_data", b_rsp_data, 32'h00A28513);
    tick();
    check("mr_no_write", b_rsp_data, 0);
    tick();
    check("mr_end", b_rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
